// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave responder: FSM encoding, bus levels
// and the position of the R/W flag in the address byte.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;
  localparam int   RW_BIT   = 0;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Register-side port of the responder. oREG_WE and oREG_RE are single-cycle
// strobes qualified by oREG_ADDR; iREG_RDATA must be valid the cycle after oREG_RE.
interface i2c_slave_responder_if;
  import i2c_pkg::*;

  logic [7:0] oREG_ADDR;
  logic [7:0] oREG_WDATA;
  logic       oREG_WE;
  logic       oREG_RE;
  logic [7:0] iREG_RDATA;
  logic       oBUSY;
  state_t     dbg_state;

  modport slave (
    output oREG_ADDR, oREG_WDATA, oREG_WE, oREG_RE, oBUSY, dbg_state,
    input  iREG_RDATA
  );

  modport master (
    input  oREG_ADDR, oREG_WDATA, oREG_WE, oREG_RE, oBUSY, dbg_state,
    output iREG_RDATA
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises and deglitches SCL/SDA, then derives SCL edges and START/STOP
// conditions from the filtered levels.
module i2c_line_sync #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_f
);

  logic [1:0]          scl_sync;
  logic [1:0]          sda_sync;
  logic [FILT_LEN-1:0] scl_hist;
  logic [FILT_LEN-1:0] sda_hist;
  logic                scl_f;
  logic                scl_q;
  logic                sda_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
      // A level is only accepted once the whole history window agrees.
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C register-access slave: address match, sub-address pointer with
// auto-increment, byte writes and streamed reads through a register port.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h21,
  parameter int         FILT_LEN   = 3
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic I2C_SCLK,
  inout  wire  I2C_SDAT,
  i2c_slave_responder_if.slave bus
);

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_f;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [6:0] rx;
  logic [7:0] tx;
  logic       sda_low;
  logic       ack_held;
  logic       rack_ok;
  logic       rd_mode;
  logic       ld_pend;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic       busy;

  logic [7:0] rx_byte;
  logic       last_bit;

  i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_line_sync (
    .clk       (iCLK),
    .rst       (iRST),
    .scl       (I2C_SCLK),
    .sda       (I2C_SDAT),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_f     (sda_f)
  );

  assign rx_byte  = {rx, sda_f};
  assign last_bit = (bit_cnt == 4'd7);

  // Open drain: only ever pull low.
  assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      rx        <= 7'd0;
      tx        <= 8'd0;
      sda_low   <= 1'b0;
      ack_held  <= 1'b0;
      rack_ok   <= 1'b0;
      rd_mode   <= 1'b0;
      ld_pend   <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      ld_pend <= reg_re;
      if (ld_pend) tx <= bus.iREG_RDATA;

      if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= 4'd0;
        sda_low  <= 1'b0;
        ack_held <= 1'b0;
        rack_ok  <= 1'b0;
      end else if (stop_det) begin
        state    <= ST_IDLE;
        sda_low  <= 1'b0;
        ack_held <= 1'b0;
        rack_ok  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            rx      <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state   <= ST_ADDR_ACK;
                busy    <= 1'b1;
                rd_mode <= rx_byte[RW_BIT];
                reg_re  <= rx_byte[RW_BIT];
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end
          end

          ST_SUB: if (scl_rise) begin
            rx      <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              reg_addr <= rx_byte;
              state    <= ST_SUB_ACK;
            end
          end

          ST_WDATA: if (scl_rise) begin
            rx      <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              reg_wdata <= rx_byte;
              reg_we    <= 1'b1;
              state     <= ST_WDATA_ACK;
            end
          end

          // ACK states: first SCL fall pulls SDA, second ends the ACK clock.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_held) begin
              sda_low  <= 1'b1;
              ack_held <= 1'b1;
            end else begin
              ack_held <= 1'b0;
              bit_cnt  <= 4'd0;
              if (rd_mode) begin
                state   <= ST_RDATA;
                sda_low <= ~tx[7];
              end else begin
                state   <= ST_SUB;
                sda_low <= 1'b0;
              end
            end
          end

          ST_SUB_ACK: if (scl_fall) begin
            if (!ack_held) begin
              sda_low  <= 1'b1;
              ack_held <= 1'b1;
            end else begin
              ack_held <= 1'b0;
              sda_low  <= 1'b0;
              bit_cnt  <= 4'd0;
              state    <= ST_WDATA;
            end
          end

          ST_WDATA_ACK: if (scl_fall) begin
            if (!ack_held) begin
              sda_low  <= 1'b1;
              ack_held <= 1'b1;
            end else begin
              ack_held <= 1'b0;
              sda_low  <= 1'b0;
              bit_cnt  <= 4'd0;
              reg_addr <= reg_addr + 8'd1;
              state    <= ST_WDATA;
            end
          end

          ST_RDATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state   <= ST_RACK;
                sda_low <= 1'b0;
              end else begin
                tx      <= tx << 1;
                sda_low <= ~tx[6];
              end
            end
          end

          // The next byte is fetched at the ACK rise and driven from the following fall.
          ST_RACK: begin
            if (scl_rise) begin
              if (sda_f == ACK_LVL) begin
                reg_addr <= reg_addr + 8'd1;
                reg_re   <= 1'b1;
                rack_ok  <= 1'b1;
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end else if (scl_fall && rack_ok) begin
              rack_ok <= 1'b0;
              bit_cnt <= 4'd0;
              sda_low <= ~tx[7];
              state   <= ST_RDATA;
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign bus.oREG_ADDR  = reg_addr;
  assign bus.oREG_WDATA = reg_wdata;
  assign bus.oREG_WE    = reg_we;
  assign bus.oREG_RE    = reg_re;
  assign bus.oBUSY      = busy;
  assign bus.dbg_state  = state;

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 Parameter SLAVE_ADDR, 7'h21, 7-bit device address this responder answers to.
REQ-002 Parameter FILT_LEN, 3, number of consecutive equal iCLK samples required to accept an SCL/SDA level change.
REQ-003 iCLK  input  1  system clock; the block uses one clock, and the reset is asynchronous and active-high.
REQ-004 iRST  input  1  asynchronous, active-high reset.
REQ-005 I2C_SCLK  input  1  I2C clock from the initiator; no clock stretching.
REQ-006 I2C_SDAT  inout  1  I2C data, open-drain: driven 0 or released to z, never driven 1.
REQ-007 oREG_ADDR  output  8  current sub-address (register pointer).
REQ-008 oREG_WDATA  output  8  received write byte.
REQ-009 oREG_WE  output  1  one-cycle write strobe for oREG_WDATA at oREG_ADDR.
REQ-010 oREG_RE  output  1  one-cycle read request for oREG_ADDR.
REQ-011 iREG_RDATA  input  8  read data, valid the iCLK cycle after oREG_RE.
REQ-012 oBUSY  output  1  high from an addressed START until STOP or NACK release.

Function
REQ-013 SCL and SDA shall pass through 2-flop synchronizers and a FILT_LEN glitch filter; all edges shall be detected on the filtered signals.
REQ-014 START shall be detected as filtered SDA falling while SCL is high, and STOP as SDA rising while SCL is high; each is evaluated in every state.
REQ-015 Data shall be sampled on the filtered SCL rising edge; SDA output changes shall occur exactly 1 iCLK after the filtered SCL falling edge.
REQ-016 States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
REQ-017 START shall enter ADDR from any state (repeated START included); the bit counter shall clear.
REQ-018 In ADDR, 8 bits shall be shifted MSB first. If bits[7:1]==SLAVE_ADDR, go to ADDR_ACK; otherwise go to IGNORE and never drive SDA.
REQ-019 In ADDR_ACK, SDA shall be driven 0 for one SCL period. With R/W=0, go next to SUB. With R/W=1, pulse oREG_RE at ADDR_ACK entry, load iREG_RDATA into the TX shifter, and go next to RDATA.
REQ-020 SUB shall receive 8 bits into oREG_ADDR, then go to SUB_ACK (ACK driven), then WDATA.
REQ-021 WDATA shall receive 8 bits; at the 8th SCL rise, set oREG_WDATA and pulse oREG_WE for 1 iCLK, then go to WDATA_ACK (ACK driven). After the ACK, oREG_ADDR shall increment mod 256 and the state returns to WDATA.
REQ-022 RDATA shall drive shifter bits MSB first, with 0 bits driven low and 1 bits released, then go to RACK with SDA released.
REQ-023 In RACK, sample SDA at the SCL rise. If 0, increment oREG_ADDR mod 256, pulse oREG_RE, reload the shifter, and return to RDATA. If 1, go to IGNORE.
REQ-024 STOP shall go to IDLE, release SDA, and clear oBUSY; oREG_ADDR is retained across STOP so that a write-subaddress/STOP/START/read sequence reads from that subaddress.
REQ-025 START or STOP occurring mid-byte shall abort the byte with no oREG_WE pulse.
REQ-026 IGNORE shall leave only on START or STOP.
REQ-027 oREG_WE and oREG_RE shall never both be high in the same cycle.

Reset
REQ-028 Asserting iRST shall immediately set state=IDLE, SDA released (z), oREG_ADDR=8'h00, oREG_WDATA=8'h00, oREG_WE=0, oREG_RE=0, oBUSY=0, and filters/synchronizers to 1.
REQ-029 Reset mid-transfer shall abandon the transfer; after release, the block shall wait for a new START.

Structure
REQ-030 A shared package i2c_pkg shall hold the state encoding, the ACK/NACK level constants, and the R/W bit position.
REQ-031 Synchronizer, filter, and START/STOP/edge detection shall be a sub-module i2c_line_sync, with outputs scl_rise, scl_fall, start_det, stop_det, and sda_f.
REQ-032 Top-level RTL is the FSM plus shifters and counters; target 150-300 lines total.

Verification
REQ-033 Write 0x42,0x10,0xA5 then STOP: three ACKs low; one oREG_WE with ADDR=0x10, WDATA=0xA5; oBUSY low after STOP.
REQ-034 Write 0x42,0x05 then STOP; then START, 0x43, iREG_RDATA=0x3C: bus byte 0x3C; oREG_RE with ADDR=0x05; master NACK leads to IGNORE.
REQ-035 Write 0x42,0xFF,0x11,0x22: WE at ADDR 0xFF then 0x00 (wrap).
REQ-036 Address 0x44: SDA never driven low; no strobes; after STOP, IDLE.
REQ-037 iRST pulsed during the 4th data bit: SDA released within 1 cycle; no WE; the next valid write transaction succeeds.
REQ-038 A 1-iCLK SDA glitch while SCL is high: no START/STOP detected (FILT_LEN=3).
